// File: rtl/secuenciador_transacciones_rtc.sv
// Sequencer that turns write, read and periodic auto-read requests into
// multi-register RTC transactions for the pulse generator.
module secuenciador_transacciones_rtc #(
   parameter logic [7:0]  CICLO_MAX       = 8'd100,
   parameter logic [3:0]  NUM_REG         = 4'd9,
   parameter logic [23:0] PERIODO_LECTURA = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sol_escritura,
   input  logic       sol_lectura,
   input  logic       habilitar_auto,
   output logic [7:0] cuenta,
   output logic [1:0] funcion,
   output logic [3:0] indice_reg,
   output logic       ocupado,
   output logic       fin_transaccion
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CICLO = 2'd1,
      FIN   = 2'd2
   } estado_t;

   localparam logic [1:0] F_IDLE = 2'b00;
   localparam logic [1:0] F_WR   = 2'b01;
   localparam logic [1:0] F_RD   = 2'b10;

   estado_t     estado_q;
   logic [7:0]  cuenta_q;
   logic [1:0]  funcion_q;
   logic [3:0]  indice_q;
   logic        ocupado_q;
   logic        fin_q;
   logic        pend_wr_q;
   logic        pend_rd_q;
   logic [23:0] timer_q;
   logic [23:0] timer_d;
   logic        auto_req;
   logic        rd_req;
   logic        wr_req;

   // Auto timer runs in every state; its expiry behaves like sol_lectura.
   always_comb begin
      timer_d  = timer_q;
      auto_req = 1'b0;
      if (!habilitar_auto) begin
         timer_d = '0;
      end else if (timer_q == PERIODO_LECTURA - 24'd1) begin
         timer_d  = '0;
         auto_req = 1'b1;
      end else begin
         timer_d = timer_q + 24'd1;
      end
   end

   assign rd_req = sol_lectura | auto_req;
   assign wr_req = sol_escritura;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q  <= IDLE;
         cuenta_q  <= '0;
         funcion_q <= F_IDLE;
         indice_q  <= '0;
         ocupado_q <= 1'b0;
         fin_q     <= 1'b0;
         pend_wr_q <= 1'b0;
         pend_rd_q <= 1'b0;
         timer_q   <= '0;
      end else begin
         timer_q <= timer_d;
         case (estado_q)
            IDLE: begin
               fin_q <= 1'b0;
               if (wr_req | pend_wr_q) begin
                  estado_q  <= CICLO;
                  funcion_q <= F_WR;
                  cuenta_q  <= '0;
                  indice_q  <= '0;
                  ocupado_q <= 1'b1;
                  pend_wr_q <= 1'b0;
                  pend_rd_q <= pend_rd_q | rd_req;
               end else if (rd_req | pend_rd_q) begin
                  estado_q  <= CICLO;
                  funcion_q <= F_RD;
                  cuenta_q  <= '0;
                  indice_q  <= '0;
                  ocupado_q <= 1'b1;
                  pend_rd_q <= 1'b0;
               end else begin
                  ocupado_q <= 1'b0;
               end
            end
            CICLO: begin
               pend_wr_q <= pend_wr_q | wr_req;
               pend_rd_q <= pend_rd_q | rd_req;
               if (cuenta_q == CICLO_MAX) begin
                  cuenta_q <= '0;
                  if (indice_q == NUM_REG - 4'd1) begin
                     estado_q  <= FIN;
                     funcion_q <= F_IDLE;
                     indice_q  <= '0;
                     fin_q     <= 1'b1;
                  end else begin
                     indice_q <= indice_q + 4'd1;
                  end
               end else begin
                  cuenta_q <= cuenta_q + 8'd1;
               end
            end
            FIN: begin
               pend_wr_q <= pend_wr_q | wr_req;
               pend_rd_q <= pend_rd_q | rd_req;
               estado_q  <= IDLE;
               fin_q     <= 1'b0;
               ocupado_q <= 1'b0;
            end
            default: begin
               estado_q  <= IDLE;
               cuenta_q  <= '0;
               funcion_q <= F_IDLE;
               indice_q  <= '0;
               ocupado_q <= 1'b0;
               fin_q     <= 1'b0;
            end
         endcase
      end
   end

   assign cuenta          = cuenta_q;
   assign funcion         = funcion_q;
   assign indice_reg      = indice_q;
   assign ocupado         = ocupado_q;
   assign fin_transaccion = fin_q;

endmodule

// File: tb/tb_secuenciador_transacciones_rtc.sv
// Directed bench for the RTC transaction sequencer with
// CICLO_MAX=4, NUM_REG=3, PERIODO_LECTURA=50.
module tb_secuenciador_transacciones_rtc;

   logic       clk;
   logic       rst;
   logic       sol_escritura;
   logic       sol_lectura;
   logic       habilitar_auto;
   logic [7:0] cuenta;
   logic [1:0] funcion;
   logic [3:0] indice_reg;
   logic       ocupado;
   logic       fin_transaccion;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   int fins   = 0;
   int snap_starts;
   int snap_fins;
   logic [1:0] prev_fun = 2'b00;

   secuenciador_transacciones_rtc #(
      .CICLO_MAX       (8'd4),
      .NUM_REG         (4'd3),
      .PERIODO_LECTURA (24'd50)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sol_escritura   (sol_escritura),
      .sol_lectura     (sol_lectura),
      .habilitar_auto  (habilitar_auto),
      .cuenta          (cuenta),
      .funcion         (funcion),
      .indice_reg      (indice_reg),
      .ocupado         (ocupado),
      .fin_transaccion (fin_transaccion)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction starts and completions observed mid-cycle.
   always @(negedge clk) begin
      if (fin_transaccion === 1'b1) fins++;
      if (funcion !== 2'b00 && prev_fun === 2'b00) starts++;
      prev_fun = funcion;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cuenta"}, 32'(cuenta), 32'd0);
      chk({tag, "_funcion"}, 32'(funcion), 32'd0);
      chk({tag, "_indice"}, 32'(indice_reg), 32'd0);
      chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
      chk({tag, "_fin"}, 32'(fin_transaccion), 32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      sol_escritura  = 1'b0;
      sol_lectura    = 1'b0;
      habilitar_auto = 1'b0;
      ticks(2);
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Single write transaction
      sol_escritura = 1'b1;
      tick();
      sol_escritura = 1'b0;
      for (int k = 0; k < 15; k++) begin
         chk("wr_funcion", 32'(funcion), 32'd1);
         chk("wr_cuenta", 32'(cuenta), 32'(k % 5));
         chk("wr_indice", 32'(indice_reg), 32'(k / 5));
         chk("wr_ocupado", 32'(ocupado), 32'd1);
         chk("wr_fin_low", 32'(fin_transaccion), 32'd0);
         tick();
      end
      chk("wr_fin", 32'(fin_transaccion), 32'd1);
      chk("wr_fin_funcion", 32'(funcion), 32'd0);
      chk("wr_fin_ocupado", 32'(ocupado), 32'd1);
      chk("wr_fin_cuenta", 32'(cuenta), 32'd0);
      tick();
      chk("wr_idle_ocupado", 32'(ocupado), 32'd0);
      chk("wr_idle_fin", 32'(fin_transaccion), 32'd0);
      chk("wr_starts", 32'(starts), 32'd1);
      chk("wr_fins", 32'(fins), 32'd1);

      // Async reset mid-cycle with nonzero outputs
      sol_escritura = 1'b1;
      tick();
      sol_escritura = 1'b0;
      ticks(3);
      chk("pre_rst_cuenta", 32'(cuenta), 32'd3);
      #2 rst = 1'b1;
      #1 chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_funcion", 32'(funcion), 32'd0);
      chk("post_rst_ocupado", 32'(ocupado), 32'd0);
      chk("rst_no_fin", 32'(fins), 32'd1);

      // Simultaneous write and read: write first, read 2 cycles after fin
      snap_starts = starts;
      snap_fins   = fins;
      sol_escritura = 1'b1;
      sol_lectura   = 1'b1;
      tick();
      sol_escritura = 1'b0;
      sol_lectura   = 1'b0;
      chk("both_wr_first", 32'(funcion), 32'd1);
      ticks(14);
      chk("both_wr_last_fun", 32'(funcion), 32'd1);
      chk("both_wr_last_idx", 32'(indice_reg), 32'd2);
      chk("both_wr_last_cta", 32'(cuenta), 32'd4);
      tick();
      chk("both_wr_fin", 32'(fin_transaccion), 32'd1);
      tick();
      chk("both_gap_funcion", 32'(funcion), 32'd0);
      chk("both_gap_ocupado", 32'(ocupado), 32'd0);
      tick();
      chk("both_rd_funcion", 32'(funcion), 32'd2);
      chk("both_rd_cuenta", 32'(cuenta), 32'd0);
      chk("both_rd_ocupado", 32'(ocupado), 32'd1);
      ticks(14);
      chk("both_rd_last_idx", 32'(indice_reg), 32'd2);
      tick();
      chk("both_rd_fin", 32'(fin_transaccion), 32'd1);
      tick();
      chk("both_rd_done", 32'(ocupado), 32'd0);
      ticks(30);
      chk("both_starts", 32'(starts), 32'(snap_starts + 2));
      chk("both_fins", 32'(fins), 32'(snap_fins + 2));

      // Two read pulses during a write merge into one read
      snap_starts = starts;
      snap_fins   = fins;
      sol_escritura = 1'b1;
      tick();
      sol_escritura = 1'b0;
      ticks(2);
      sol_lectura = 1'b1;
      tick();
      sol_lectura = 1'b0;
      ticks(4);
      sol_lectura = 1'b1;
      tick();
      sol_lectura = 1'b0;
      ticks(7);
      chk("merge_wr_fin", 32'(fin_transaccion), 32'd1);
      tick();
      chk("merge_gap", 32'(funcion), 32'd0);
      tick();
      chk("merge_rd", 32'(funcion), 32'd2);
      ticks(15);
      chk("merge_rd_fin", 32'(fin_transaccion), 32'd1);
      ticks(40);
      chk("merge_starts", 32'(starts), 32'(snap_starts + 2));
      chk("merge_fins", 32'(fins), 32'(snap_fins + 2));

      // Periodic auto-read, one expiry landing inside a write
      snap_starts = starts;
      habilitar_auto = 1'b1;
      ticks(49);
      chk("auto1_pre", 32'(funcion), 32'd0);
      tick();
      chk("auto1_rd", 32'(funcion), 32'd2);
      ticks(49);
      chk("auto2_pre_fun", 32'(funcion), 32'd0);
      chk("auto2_pre_ocup", 32'(ocupado), 32'd0);
      tick();
      chk("auto2_rd", 32'(funcion), 32'd2);
      ticks(39);
      sol_escritura = 1'b1;
      tick();
      sol_escritura = 1'b0;
      chk("auto3_wr", 32'(funcion), 32'd1);
      ticks(15);
      chk("auto3_wr_fin", 32'(fin_transaccion), 32'd1);
      tick();
      chk("auto3_gap", 32'(funcion), 32'd0);
      tick();
      chk("auto3_rd", 32'(funcion), 32'd2);
      habilitar_auto = 1'b0;
      ticks(15);
      chk("auto3_rd_fin", 32'(fin_transaccion), 32'd1);
      ticks(100);
      chk("auto_starts", 32'(starts), 32'(snap_starts + 4));

      // Reset at indice 1, cuenta 2 with a pending read
      sol_escritura = 1'b1;
      tick();
      sol_escritura = 1'b0;
      tick();
      sol_lectura = 1'b1;
      tick();
      sol_lectura = 1'b0;
      ticks(5);
      chk("abort_idx", 32'(indice_reg), 32'd1);
      chk("abort_cta", 32'(cuenta), 32'd2);
      snap_starts = starts;
      snap_fins   = fins;
      #2 rst = 1'b1;
      #1 chk_zero("abort_rst");
      @(negedge clk);
      rst = 1'b0;
      ticks(200);
      chk("abort_starts", 32'(starts), 32'(snap_starts));
      chk("abort_fins", 32'(fins), 32'(snap_fins));
      chk("abort_funcion", 32'(funcion), 32'd0);
      chk("abort_ocupado", 32'(ocupado), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
